// File: rtl/lfsr_match_ctrl.sv
// Sequencer for an external trigger LFSR: seeds it, steps it until the state matches a
// programmed pattern or a step budget is exhausted, then reports hit and step count.
module lfsr_match_ctrl #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] max_steps,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed_o,
    output logic             lfsr_en,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] steps
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             match;
    logic             budget_out;

    localparam logic [WIDTH-1:0] SeedOne = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    assign match      = (lfsr_q == pattern_q);
    assign budget_out = (cnt_q == max_q);

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        pattern_d = pattern_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        steps_d   = steps_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // An all-zero seed would lock the LFSR up.
                    seed_d    = (seed == '0) ? SeedOne : seed;
                    pattern_d = pattern;
                    max_d     = max_steps;
                    cnt_d     = '0;
                    hit_d     = 1'b0;
                    steps_d   = '0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                lfsr_load = 1'b1;
                state_d   = abort ? StDone : StRun;
            end
            StRun: begin
                lfsr_en = !match && !budget_out && !abort;
                if (lfsr_en) begin
                    cnt_d = cnt_q + CntOne;
                end
                if (match) begin
                    hit_d   = 1'b1;
                    state_d = StDone;
                end else if (abort || budget_out) begin
                    hit_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                steps_d = cnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            seed_q    <= '0;
            pattern_q <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            steps_q   <= '0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            pattern_q <= pattern_d;
            max_q     <= max_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            steps_q   <= steps_d;
        end
    end

    assign lfsr_seed_o = seed_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign hit         = hit_q;
    assign steps       = steps_q;

endmodule
